// File: rtl/conv1_act_sched_if.sv
// Bundles the control, accumulator-stream and SRAM-write signals of the Conv1 activation scheduler.
// The master side is the environment (controller, accumulator source, SRAM); the slave side is the scheduler.
interface conv1_act_sched_if #(
  parameter int IN_W   = 20,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_pix;
  logic              busy;
  logic              done;
  logic              acc_valid;
  logic              acc_ready;
  logic [IN_W-1:0]   acc_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;

  modport master (
    output start, base_addr, num_pix, acc_valid, acc_data, wr_ready,
    input  busy, done, acc_ready, wr_valid, wr_addr, wr_data, wr_strb
  );

  modport slave (
    input  start, base_addr, num_pix, acc_valid, acc_data, wr_ready,
    output busy, done, acc_ready, wr_valid, wr_addr, wr_data, wr_strb
  );
endinterface

// File: rtl/conv1_act_sched.sv
// Conv1 activation sequencer: requant+ReLU on 20-bit accumulator sums, packs four bytes per word
// and writes them to consecutive feature-map SRAM words starting at the latched base address.
module conv1_act_sched #(
  parameter int IN_W   = 20,
  parameter int SHIFT1 = 2,
  parameter int BIAS   = 128,
  parameter int SHIFT2 = 5,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  conv1_act_sched_if.slave   bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNT_W-1:0]  ONE_PIX  = 1;
  localparam logic [ADDR_W-1:0] ONE_WORD = 1;
  localparam logic [IN_W:0]     BIAS_W   = (IN_W+1)'(BIAS);
  localparam logic [IN_W:0]     SAT_MAX  = (IN_W+1)'(127);

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] word_idx;
  logic [CNT_W-1:0]  num_reg;
  logic [CNT_W-1:0]  pix_cnt;
  logic [31:0]       pack;
  logic [31:0]       pack_next;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [3:0]        wr_strb_q;

  logic [IN_W-1:0]   acc_shift;
  logic signed [IN_W:0] t1;
  logic signed [IN_W:0] t2;
  logic [7:0]        act_byte;
  logic [1:0]        lane;
  logic [3:0]        lane_strb;
  logic              beat;
  logic              last_pix;
  logic              word_done;
  logic              wr_fire;

  // Requant: drop SHIFT1 LSBs, remove bias, arithmetic shift, then clamp into [0,127].
  always_comb begin
    acc_shift = bus.acc_data >> SHIFT1;
    t1        = $signed({1'b0, acc_shift}) - $signed(BIAS_W);
    t2        = t1 >>> SHIFT2;
    if (t2[IN_W])
      act_byte = 8'd0;
    else if (t2 > $signed(SAT_MAX))
      act_byte = 8'd127;
    else
      act_byte = {1'b0, t2[6:0]};
  end

  assign lane      = pix_cnt[1:0];
  assign last_pix  = (pix_cnt + ONE_PIX) == num_reg;
  assign word_done = (lane == 2'd3) || last_pix;
  assign wr_fire   = wr_valid_q && bus.wr_ready;

  always_comb begin
    pack_next                = pack;
    pack_next[lane*8 +: 8]   = act_byte;
    case (lane)
      2'd0:    lane_strb = 4'h1;
      2'd1:    lane_strb = 4'h3;
      2'd2:    lane_strb = 4'h7;
      default: lane_strb = 4'hF;
    endcase
  end

  // A beat is only taken when the output word slot is free or retiring this cycle.
  assign bus.acc_ready = (state == RUN) && (!wr_valid_q || bus.wr_ready);
  assign beat          = bus.acc_valid && bus.acc_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base_reg   <= '0;
      num_reg    <= '0;
      pix_cnt    <= '0;
      word_idx   <= '0;
      pack       <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
    end else begin
      if (wr_fire)
        wr_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            base_reg <= bus.base_addr;
            num_reg  <= bus.num_pix;
            pix_cnt  <= '0;
            word_idx <= '0;
            pack     <= '0;
            state    <= (bus.num_pix == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (beat) begin
            pix_cnt <= pix_cnt + ONE_PIX;
            // A completing beat loads the word directly; this overrides any retire above.
            if (word_done) begin
              wr_valid_q <= 1'b1;
              wr_data_q  <= pack_next;
              wr_strb_q  <= lane_strb;
              wr_addr_q  <= base_reg + word_idx;
              word_idx   <= word_idx + ONE_WORD;
              pack       <= '0;
            end else begin
              pack <= pack_next;
            end
            if (last_pix)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (wr_fire)
            state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (state == RUN) || (state == DRAIN);
  assign bus.done     = (state == DONE);
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_strb  = wr_strb_q;

endmodule
